// File: rtl/rob_pkg.sv
// Shared ROB tag type and phase-bit age comparison used by the age-ordered issue buffer.
package rob_pkg;

   localparam int unsigned ROB_TAG_WIDTH = 3;
   localparam int unsigned ROB_PHASE_BIT = ROB_TAG_WIDTH;

   typedef logic [ROB_TAG_WIDTH:0] rob_tag_t;

   // a is younger than b; the phase bit flips the index order once the ROB wraps
   function automatic logic rob_younger(input rob_tag_t a, input rob_tag_t b);
      return (a[ROB_TAG_WIDTH-1:0] > b[ROB_TAG_WIDTH-1:0]) ^
             (a[ROB_PHASE_BIT] ^ b[ROB_PHASE_BIT]);
   endfunction

endpackage

// File: rtl/age_oldest_select.sv
// Combinational oldest-candidate picker: pairwise age matrix, AND-reduce per row, lowest index on tie.
module age_oldest_select
   import rob_pkg::*;
#(
   parameter int unsigned N_SLOTS        = 4,
   parameter int unsigned SLOT_IDX_WIDTH = $clog2(N_SLOTS)
) (
   input  logic [N_SLOTS-1:0]        cand,
   input  rob_tag_t [N_SLOTS-1:0]    tags,
   output logic                      found,
   output logic [SLOT_IDX_WIDTH-1:0] oldest_slot,
   output rob_tag_t                  oldest_tag
);

   logic [N_SLOTS-1:0] beats [N_SLOTS];
   logic [N_SLOTS-1:0] win;

   // row i wins when every other candidate is younger, or ties and sits at a higher slot
   always_comb begin
      beats = '{default: '0};
      win   = '0;
      for (int i = 0; i < int'(N_SLOTS); i++) begin
         for (int j = 0; j < int'(N_SLOTS); j++) begin
            beats[i][j] = (i == j) || !cand[j] ||
                          (!rob_younger(tags[i], tags[j]) &&
                           (rob_younger(tags[j], tags[i]) || (i < j)));
         end
         win[i] = cand[i] && (&beats[i]);
      end
   end

   always_comb begin
      oldest_slot = '0;
      for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
         if (win[i]) oldest_slot = SLOT_IDX_WIDTH'(i);
      end
   end

   assign found      = |cand;
   assign oldest_tag = tags[oldest_slot];

endmodule

// File: rtl/rob_age_select_buffer.sv
// N-slot buffer of ROB tags presenting the oldest ready entry for issue, with tag wakeup and
// mispredict flush of everything strictly younger than the flush tag.
module rob_age_select_buffer
   import rob_pkg::*;
#(
   parameter int unsigned N_SLOTS        = 4,
   parameter int unsigned SLOT_IDX_WIDTH = $clog2(N_SLOTS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      alloc_valid,
   input  rob_tag_t                  alloc_tag,
   input  logic                      alloc_is_ready,
   output logic                      alloc_ready,
   input  logic                      wakeup_valid,
   input  rob_tag_t                  wakeup_tag,
   output logic                      issue_valid,
   output rob_tag_t                  issue_tag,
   output logic [SLOT_IDX_WIDTH-1:0] issue_slot,
   input  logic                      issue_ready,
   input  logic                      flush_valid,
   input  rob_tag_t                  flush_tag,
   output logic [SLOT_IDX_WIDTH:0]   count
);

   localparam int unsigned CNT_W = SLOT_IDX_WIDTH + 1;

   logic [N_SLOTS-1:0]        valid_q, valid_d, ready_q, ready_d, cand;
   rob_tag_t [N_SLOTS-1:0]    tag_q, tag_d;
   logic [CNT_W-1:0]          count_q, count_d, killed;
   logic                      sel_found, issue_fire, alloc_fire, alloc_wake;
   logic [SLOT_IDX_WIDTH-1:0] sel_slot, alloc_slot;
   rob_tag_t                  sel_tag;

   assign cand = valid_q & ready_q;

   age_oldest_select #(
      .N_SLOTS        (N_SLOTS),
      .SLOT_IDX_WIDTH (SLOT_IDX_WIDTH)
   ) u_select (
      .cand        (cand),
      .tags        (tag_q),
      .found       (sel_found),
      .oldest_slot (sel_slot),
      .oldest_tag  (sel_tag)
   );

   assign alloc_ready = (count_q < CNT_W'(N_SLOTS)) && !flush_valid;
   assign issue_valid = sel_found && !flush_valid;
   assign issue_tag   = sel_tag;
   assign issue_slot  = sel_slot;
   assign count       = count_q;
   assign issue_fire  = issue_valid && issue_ready;
   assign alloc_fire  = alloc_valid && alloc_ready;
   assign alloc_wake  = wakeup_valid && (wakeup_tag == alloc_tag);

   // lowest slot free at cycle start; slots freed by this cycle's issue are not reused
   always_comb begin
      alloc_slot = '0;
      for (int i = int'(N_SLOTS) - 1; i >= 0; i--) begin
         if (!valid_q[i]) alloc_slot = SLOT_IDX_WIDTH'(i);
      end
   end

   always_comb begin
      valid_d = valid_q;
      ready_d = ready_q;
      tag_d   = tag_q;
      killed  = '0;
      for (int i = 0; i < int'(N_SLOTS); i++) begin
         if (valid_q[i] && wakeup_valid && (tag_q[i] == wakeup_tag)) ready_d[i] = 1'b1;
         if (flush_valid && valid_q[i] && rob_younger(tag_q[i], flush_tag)) begin
            valid_d[i] = 1'b0;
            killed     = killed + CNT_W'(1);
         end
      end
      if (issue_fire) valid_d[sel_slot] = 1'b0;
      if (alloc_fire) begin
         valid_d[alloc_slot] = 1'b1;
         ready_d[alloc_slot] = alloc_is_ready || alloc_wake;
         tag_d[alloc_slot]   = alloc_tag;
      end
      count_d = count_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire) - killed;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         ready_q <= '0;
         count_q <= '0;
      end else begin
         valid_q <= valid_d;
         ready_q <= ready_d;
         count_q <= count_d;
      end
   end

   // tags carry no reset; they are only observed behind a valid bit
   always_ff @(posedge clk) begin
      tag_q <= tag_d;
   end

   count_tracks_valid: assert property (@(posedge clk) disable iff (reset)
      count_q == CNT_W'($countones(valid_q)));

endmodule

// File: tb/tb_rob_age_select_buffer.sv
// Scoreboarded bench: a slot-level reference model queues expected outputs per cycle, a monitor checks them.
module tb_rob_age_select_buffer;
   import rob_pkg::*;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       reset, alloc_valid, alloc_is_ready, alloc_ready, wakeup_valid;
   logic       issue_valid, issue_ready, flush_valid;
   rob_tag_t   alloc_tag, wakeup_tag, issue_tag, flush_tag;
   logic [1:0] issue_slot;
   logic [2:0] count;

   always #5 clk = ~clk;

   rob_age_select_buffer #(.N_SLOTS(N)) dut (
      .clk            (clk),
      .reset          (reset),
      .alloc_valid    (alloc_valid),
      .alloc_tag      (alloc_tag),
      .alloc_is_ready (alloc_is_ready),
      .alloc_ready    (alloc_ready),
      .wakeup_valid   (wakeup_valid),
      .wakeup_tag     (wakeup_tag),
      .issue_valid    (issue_valid),
      .issue_tag      (issue_tag),
      .issue_slot     (issue_slot),
      .issue_ready    (issue_ready),
      .flush_valid    (flush_valid),
      .flush_tag      (flush_tag),
      .count          (count)
   );

   typedef struct {
      bit       iv;
      bit [3:0] tag;
      int       slot;
      bit       ar;
      int       cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   // reference model: per-slot contents
   bit       m_v[N];
   bit       m_r[N];
   bit [3:0] m_t[N];

   // stimulus for the next cycle
   bit       s_rst, s_av, s_air, s_wv, s_ir, s_fv;
   bit [3:0] s_at, s_wt, s_ft;
   bit [3:0] next_tag;

   // a is younger than b when it lies 1..7 steps ahead on the 16-entry tag circle
   function automatic bit younger_m(bit [3:0] a, bit [3:0] b);
      bit [3:0] d;
      d = a - b;
      return (d != 4'd0) && (d < 4'd8);
   endfunction

   // slot whose tag every other candidate is at or ahead of; scanning upward gives ties to the lower slot
   function automatic int oldest_ready();
      bit       ok;
      bit [3:0] d;
      for (int c = 0; c < N; c++) begin
         if (m_v[c] && m_r[c]) begin
            ok = 1'b1;
            for (int o = 0; o < N; o++) begin
               d = m_t[o] - m_t[c];
               if (m_v[o] && m_r[o] && d >= 4'd8) ok = 1'b0;
            end
            if (ok) return c;
         end
      end
      return -1;
   endfunction

   function automatic bit oldest_live(output bit [3:0] o);
      bit       ok;
      bit [3:0] d;
      o = 4'd0;
      for (int c = 0; c < N; c++) begin
         if (m_v[c]) begin
            ok = 1'b1;
            for (int x = 0; x < N; x++) begin
               d = m_t[x] - m_t[c];
               if (m_v[x] && d >= 4'd8) ok = 1'b0;
            end
            if (ok) begin
               o = m_t[c];
               return 1'b1;
            end
         end
      end
      return 1'b0;
   endfunction

   function automatic int live_count();
      int n;
      n = 0;
      for (int i = 0; i < N; i++) n += int'(m_v[i]);
      return n;
   endfunction

   task automatic clr_s();
      s_rst = 0; s_av = 0; s_air = 0; s_wv = 0; s_ir = 0; s_fv = 0;
      s_at = 0; s_wt = 0; s_ft = 0;
   endtask

   // apply one cycle of stimulus, queue the expected outputs, advance the model
   task automatic tick();
      exp_t e;
      int   sel;
      int   slot;
      int   cnt;
      @(posedge clk);
      #1;
      reset = s_rst; alloc_valid = s_av; alloc_tag = s_at; alloc_is_ready = s_air;
      wakeup_valid = s_wv; wakeup_tag = s_wt; issue_ready = s_ir;
      flush_valid = s_fv; flush_tag = s_ft;
      sel   = oldest_ready();
      cnt   = live_count();
      e.iv  = (sel >= 0) && !s_fv;
      e.tag = (sel >= 0) ? m_t[sel] : 4'd0;
      e.slot = sel;
      e.ar  = (cnt < N) && !s_fv;
      e.cnt = cnt;
      exp_q.push_back(e);
      if (s_rst) begin
         for (int i = 0; i < N; i++) begin
            m_v[i] = 0;
            m_r[i] = 0;
         end
      end else begin
         slot = -1;
         for (int i = 0; i < N; i++) if (!m_v[i] && slot < 0) slot = i;
         for (int i = 0; i < N; i++) begin
            if (m_v[i] && s_wv && m_t[i] == s_wt) m_r[i] = 1;
            if (s_fv && m_v[i] && younger_m(m_t[i], s_ft)) m_v[i] = 0;
         end
         if (e.iv && s_ir) m_v[sel] = 0;
         if (s_av && e.ar) begin
            m_v[slot] = 1;
            m_r[slot] = s_air || (s_wv && s_wt == s_at);
            m_t[slot] = s_at;
         end
      end
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0d, required %0d at %0t", nm, act, req, $time);
      end
   endtask

   // monitor: compares once per cycle, mid-cycle, against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue_valid", 32'(issue_valid), 32'(e.iv));
            chk("alloc_ready", 32'(alloc_ready), 32'(e.ar));
            chk("count", 32'(count), e.cnt);
            if (e.iv) begin
               chk("issue_tag", 32'(issue_tag), 32'(e.tag));
               chk("issue_slot", 32'(issue_slot), e.slot);
            end
         end
      end
   end

   initial begin
      bit [3:0] o;
      bit [3:0] span;
      bit       live;
      reset = 1; alloc_valid = 0; alloc_tag = 0; alloc_is_ready = 0; wakeup_valid = 0;
      wakeup_tag = 0; issue_ready = 0; flush_valid = 0; flush_tag = 0;
      for (int i = 0; i < N; i++) begin
         m_v[i] = 0; m_r[i] = 0; m_t[i] = 0;
      end
      clr_s(); s_rst = 1;
      tick(); tick();

      // in-order issue of three ready tags
      clr_s(); s_ir = 1; s_av = 1; s_air = 1;
      for (int t = 1; t <= 3; t++) begin s_at = 4'(t); tick(); end
      s_av = 0; tick(); tick();

      // phase wrap 6,7,8,9
      clr_s(); s_av = 1; s_air = 1;
      for (int t = 6; t <= 9; t++) begin s_at = 4'(t); tick(); end
      s_av = 0; tick();
      s_ir = 1; repeat (4) tick();
      s_ir = 0; tick();

      // wakeup reorders the offer
      clr_s(); s_av = 1; s_at = 4'h2; tick();
      s_at = 4'h4; s_air = 1; tick();
      s_av = 0; tick();
      s_wv = 1; s_wt = 4'h2; tick();
      s_wv = 0; tick();
      s_ir = 1; repeat (3) tick();

      // full buffer, no bypass through a same-cycle issue
      clr_s(); s_av = 1; s_air = 1;
      for (int t = 10; t <= 13; t++) begin s_at = 4'(t); tick(); end
      s_av = 0; tick();
      s_av = 1; s_at = 4'hE; s_ir = 1; tick();
      s_av = 0; s_ir = 0; tick();
      s_ir = 1; repeat (4) tick();

      // flush keeps the boundary tag, blocks issue and alloc that cycle
      clr_s(); s_av = 1; s_air = 1;
      for (int t = 3; t <= 6; t++) begin s_at = 4'(t); tick(); end
      s_at = 4'h7; s_fv = 1; s_ft = 4'h4; s_ir = 1; tick();
      clr_s(); tick();
      s_ir = 1; repeat (3) tick();
      clr_s(); s_av = 1; s_air = 1;
      s_at = 4'hE; tick(); s_at = 4'hF; tick(); s_at = 4'h0; tick();
      s_av = 0; s_fv = 1; s_ft = 4'hF; tick();
      clr_s(); tick();
      s_ir = 1; repeat (3) tick();

      // alloc woken in flight, then reset with three live entries
      clr_s(); s_av = 1; s_at = 4'h5; s_wv = 1; s_wt = 4'h5; tick();
      clr_s(); tick();
      s_av = 1; s_at = 4'h6; tick(); s_at = 4'h7; tick();
      s_av = 1; s_at = 4'h8; s_rst = 1; tick();
      clr_s(); tick(); tick();

      // random traffic with live tags kept inside an 8-tag window
      next_tag = 4'h0;
      for (int k = 0; k < 1500; k++) begin
         live = oldest_live(o);
         span = next_tag - o;
         clr_s();
         s_rst = ($urandom_range(0, 149) == 0);
         s_ir  = ($urandom_range(0, 2) != 0);
         s_wv  = 1'($urandom_range(0, 1));
         s_wt  = live ? o + 4'($urandom_range(0, 7)) : next_tag;
         if (live && $urandom_range(0, 11) == 0) begin
            s_fv = 1;
            s_ft = o + 4'($urandom_range(0, int'(span) - 1));
            next_tag = s_ft + 4'd1;
         end else if ($urandom_range(0, 2) != 0 && (!live || span < 4'd7)) begin
            s_av  = 1;
            s_at  = next_tag;
            s_air = 1'($urandom_range(0, 1));
            if (live_count() < N) next_tag = next_tag + 4'd1;
         end
         tick();
      end

      clr_s(); s_ir = 1; repeat (6) tick();
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
